// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter: round-robin or fixed priority, done/drop release, watchdog reclaim.
// Latency: grant 1 cycle after request in IDLE; each tenure ends with one RELEASE cycle then IDLE.
// Backpressure: none; requests are levels held by masters until granted, owner is never preempted.
module bus_arbiter_nm #(
    parameter int NUM_MASTERS    = 4,
    parameter int SLAVE_SEL_W    = 2,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MID_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             m_request,
    input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0] m_slave_select,
    input  logic [NUM_MASTERS-1:0]             m_done,
    output logic [NUM_MASTERS-1:0]             m_grant,
    output logic                               busy,
    output logic [MID_W-1:0]                   bus_grant,
    output logic [SLAVE_SEL_W-1:0]             slave_grant,
    output logic                               timeout,
    output logic [MID_W-1:0]                   timeout_id
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t                 state;
    logic [MID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       wd_cnt;

    logic [SLAVE_SEL_W-1:0] sel_arr [NUM_MASTERS];
    logic [MID_W-1:0]       win_idx;
    logic                   win_vld;
    logic [MID_W-1:0]       cand;
    logic                   own_req;
    logic                   own_done;
    logic                   wd_hit;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_arr[i] = m_slave_select[i*SLAVE_SEL_W +: SLAVE_SEL_W];
        end
    end

    // Round-robin search starts just above the last owner so it sees lowest priority next time.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (PRIORITY_MODE != 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                cand = MID_W'(i);
                if (m_request[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = MID_W'((int'(rr_ptr) + k) % NUM_MASTERS);
                if (!win_vld && m_request[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    assign own_req  = m_request[bus_grant];
    assign own_done = m_done[bus_grant];
    assign wd_hit   = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            m_grant     <= '0;
            busy        <= 1'b0;
            bus_grant   <= '0;
            slave_grant <= '0;
            timeout     <= 1'b0;
            timeout_id  <= '0;
            rr_ptr      <= MID_W'(NUM_MASTERS - 1);
            wd_cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        state       <= S_GRANT;
                        m_grant     <= NUM_MASTERS'(1) << win_idx;
                        busy        <= 1'b1;
                        bus_grant   <= win_idx;
                        slave_grant <= sel_arr[win_idx];
                        rr_ptr      <= win_idx;
                        wd_cnt      <= '0;
                    end
                end
                S_GRANT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (own_done || !own_req || wd_hit) begin
                        state   <= S_RELEASE;
                        m_grant <= '0;
                        busy    <= 1'b0;
                        // Only a pure watchdog expiry is reported; a normal release wins the tie.
                        if (!own_done && own_req) begin
                            timeout    <= 1'b1;
                            timeout_id <= bus_grant;
                        end
                    end
                end
                S_RELEASE: begin
                    state       <= S_IDLE;
                    bus_grant   <= '0;
                    slave_grant <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    m_grant <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench for bus_arbiter_nm: vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter_nm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [7:0] sel = '0;

    logic [3:0] grant_rr, grant_fp, grant_nt;
    logic       busy_rr, busy_fp, busy_nt;
    logic [1:0] bg_rr, bg_fp, bg_nt;
    logic [1:0] sg_rr, sg_fp, sg_nt;
    logic       to_rr, to_fp, to_nt;
    logic [1:0] tid_rr, tid_fp, tid_nt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_nm #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .reset(reset), .m_request(req), .m_slave_select(sel), .m_done(done),
        .m_grant(grant_rr), .busy(busy_rr), .bus_grant(bg_rr), .slave_grant(sg_rr),
        .timeout(to_rr), .timeout_id(tid_rr));

    bus_arbiter_nm #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) u_fp (
        .clk(clk), .reset(reset), .m_request(req), .m_slave_select(sel), .m_done(done),
        .m_grant(grant_fp), .busy(busy_fp), .bus_grant(bg_fp), .slave_grant(sg_fp),
        .timeout(to_fp), .timeout_id(tid_fp));

    bus_arbiter_nm #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(0)) u_nt (
        .clk(clk), .reset(reset), .m_request(req), .m_slave_select(sel), .m_done(done),
        .m_grant(grant_nt), .busy(busy_nt), .bus_grant(bg_nt), .slave_grant(sg_nt),
        .timeout(to_nt), .timeout_id(tid_nt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        done  = '0;
        sel   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grant_rr();
        int n = 0;
        while (grant_rr == 4'b0000 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("inv_busy_rr", {31'd0, busy_rr}, {31'd0, |grant_rr});
            chk("inv_onehot_rr", {31'd0, $onehot0(grant_rr)}, 32'd1);
            chk("inv_busy_fp", {31'd0, busy_fp}, {31'd0, |grant_fp});
            chk("inv_onehot_fp", {31'd0, $onehot0(grant_fp)}, 32'd1);
            chk("inv_busy_nt", {31'd0, busy_nt}, {31'd0, |grant_nt});
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] sel;
        logic [3:0] done;
        logic [3:0] e_grant;
        logic       e_busy;
        logic [1:0] e_bg;
        logic [1:0] e_sg;
        logic       e_to;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int cnt;

        // req, sel, done -> grant, busy, bus_grant, slave_grant, timeout
        tbl[0]  = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{4'b0100, 8'h30, 4'b0000, 4'b0100, 1'b1, 2'd2, 2'd3, 1'b0};
        tbl[2]  = '{4'b0100, 8'h10, 4'b0000, 4'b0100, 1'b1, 2'd2, 2'd3, 1'b0};
        tbl[3]  = '{4'b0100, 8'h10, 4'b0100, 4'b0000, 1'b0, 2'd2, 2'd3, 1'b0};
        tbl[4]  = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[5]  = '{4'b0001, 8'h02, 4'b0000, 4'b0001, 1'b1, 2'd0, 2'd2, 1'b0};
        tbl[6]  = '{4'b1001, 8'h02, 4'b1000, 4'b0001, 1'b1, 2'd0, 2'd2, 1'b0};
        tbl[7]  = '{4'b1001, 8'h02, 4'b1000, 4'b0001, 1'b1, 2'd0, 2'd2, 1'b0};
        tbl[8]  = '{4'b1000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd2, 1'b0};
        tbl[9]  = '{4'b1000, 8'h40, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[10] = '{4'b1000, 8'h40, 4'b0000, 4'b1000, 1'b1, 2'd3, 2'd1, 1'b0};
        tbl[11] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd3, 2'd1, 1'b0};
        tbl[12] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", {28'd0, grant_rr}, 32'd0);
        chk("rst_busy", {31'd0, busy_rr}, 32'd0);
        chk("rst_bg", {30'd0, bg_rr}, 32'd0);
        chk("rst_sg", {30'd0, sg_rr}, 32'd0);
        chk("rst_to", {31'd0, to_rr}, 32'd0);
        chk("rst_tid", {30'd0, tid_rr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("idle_grant", {28'd0, grant_rr}, 32'd0);
            chk("idle_busy", {31'd0, busy_rr}, 32'd0);
        end

        // Vector table: single master, frozen select, non-owner done, no preemption
        for (int i = 0; i < 13; i++) begin
            req  = tbl[i].req;
            sel  = tbl[i].sel;
            done = tbl[i].done;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_grant", i), {28'd0, grant_rr}, {28'd0, tbl[i].e_grant});
            chk($sformatf("v%0d_busy", i), {31'd0, busy_rr}, {31'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_bg", i), {30'd0, bg_rr}, {30'd0, tbl[i].e_bg});
            chk($sformatf("v%0d_sg", i), {30'd0, sg_rr}, {30'd0, tbl[i].e_sg});
            chk($sformatf("v%0d_to", i), {31'd0, to_rr}, {31'd0, tbl[i].e_to});
        end

        // Round-robin order vs fixed priority, all masters requesting
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_grant_rr();
            chk($sformatf("rr_order%0d", r), {30'd0, bg_rr}, r % 4);
            chk($sformatf("rr_grant%0d", r), {28'd0, grant_rr}, 32'd1 << (r % 4));
            chk($sformatf("fp_grant%0d", r), {28'd0, grant_fp}, 32'd1);
            @(posedge clk);
            #1;
            done = grant_rr | grant_fp;
            @(posedge clk);
            #1;
            done = '0;
            chk($sformatf("rr_rel%0d", r), {28'd0, grant_rr}, 32'd0);
        end

        // Asynchronous reset while master 2 owns the bus
        do_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("mid_pre_grant", {28'd0, grant_rr}, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", {28'd0, grant_rr}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_rr}, 32'd0);
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant", {28'd0, grant_rr}, 32'h1);
        chk("post_rst_bg", {30'd0, bg_rr}, 32'd0);

        // Watchdog: master 1 never finishes
        do_reset();
        req = 4'b0010;
        wait_grant_rr();
        cnt = 0;
        while (grant_rr == 4'b0010 && cnt < 20) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        chk("wd_len", cnt, 32'd8);
        chk("wd_to", {31'd0, to_rr}, 32'd1);
        chk("wd_tid", {30'd0, tid_rr}, 32'd1);
        chk("wd_grant", {28'd0, grant_rr}, 32'd0);
        @(posedge clk);
        #1;
        chk("wd_to_pulse", {31'd0, to_rr}, 32'd0);
        chk("wd_tid_hold", {30'd0, tid_rr}, 32'd1);
        repeat (110) @(posedge clk);
        #1;
        chk("nowd_grant", {28'd0, grant_nt}, 32'h2);
        chk("nowd_busy", {31'd0, busy_nt}, 32'd1);
        chk("nowd_to", {31'd0, to_nt}, 32'd0);

        req = '0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_nm.md
Name: bus_arbiter_nm

Overview:
- N-master system-bus arbiter; parametrised successor of the two-master arbiter.
- Grants exclusive bus ownership to one master at a time and routes that master's slave select to the slave decoder.
- Selectable round-robin or fixed-priority arbitration, explicit transaction-done release, and a watchdog timeout that forcibly reclaims the bus.
- Sits between the master interfaces and the bus mux/slave decoder.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
SLAVE_SEL_W, 2, width of each master's slave-select field
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 255, max cycles in GRANT before forced release; 0 disables the watchdog
MID_W, clog2(NUM_MASTERS) (min 1), width of master index

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
m_request  in  NUM_MASTERS  per-master bus request, level
m_slave_select  in  NUM_MASTERS*SLAVE_SEL_W  per-master slave select; master i at bits [i*SLAVE_SEL_W +: SLAVE_SEL_W]
m_done  in  NUM_MASTERS  per-master transaction-done pulse; only the owner's bit is honoured
m_grant  out  NUM_MASTERS  one-hot grant, registered
busy  out  1  high while the bus is owned (GRANT state)
bus_grant  out  MID_W  index of the current owner, registered
slave_grant  out  SLAVE_SEL_W  slave select latched from the owner at grant
timeout  out  1  one-cycle pulse when the watchdog forces release
timeout_id  out  MID_W  index of the master that timed out; holds until the next timeout

Behaviour:
- Reset (reset=0, async): state=IDLE; m_grant=0, busy=0, bus_grant=0, slave_grant=0, timeout=0, timeout_id=0; rr_ptr=NUM_MASTERS-1; watchdog counter=0. Reset asserted mid-transaction drops the grant immediately, with no RELEASE cycle.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any m_request bit is set, choose winner W and go to GRANT at the next edge.
  - At that edge: m_grant=1<<W, bus_grant=W, slave_grant=select[W], busy=1, counter=0.
  - Latency from request to grant: 1 cycle.
  - If no request is set, stay in IDLE with all outputs low.
- Winner selection:
  - PRIORITY_MODE=1: lowest set request index.
  - PRIORITY_MODE=0: first set request searching upward from rr_ptr+1, modulo NUM_MASTERS.
  - rr_ptr is updated to W on entry to GRANT.
- GRANT:
  - slave_grant is frozen; later changes to the owner's select are ignored.
  - Counter increments every cycle.
  - Leave to RELEASE at the next edge on the first of:
    - (a) m_done[W]=1;
    - (b) m_request[W]=0;
    - (c) TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1.
  - On (c) only, and only if (a) and (b) are both false in that cycle: timeout=1 for exactly the RELEASE cycle, timeout_id=W.
  - m_done from non-owners is ignored.
  - A new request from another master has no effect on the current owner (no preemption).
- RELEASE:
  - Exactly one cycle with m_grant=0, busy=0; bus_grant and slave_grant hold their last values.
  - Always go to IDLE at the next edge. No arbitration happens in this cycle; requests are simply held by masters.
- Turnaround:
  - Back-to-back owners are separated by RELEASE + IDLE: a grant edge at most every 3 cycles per transaction.
  - If a released master's request stays high, it competes normally in IDLE; round-robin gives others priority first.
- Invariants:
  - m_grant is always zero or one-hot.
  - busy == |m_grant.
  - m_grant is nonzero only in GRANT.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, then release with m_request=0 -> all outputs 0 and stay 0 for 10 cycles; m_grant never nonzero.
- Single master: NUM_MASTERS=4, m_request=4'b0100, select[2]=2'b11 -> one cycle later m_grant=4'b0100, bus_grant=2, slave_grant=3, busy=1. Change select[2] mid-grant -> slave_grant stays 3. Pulse m_done[2] -> next cycle m_grant=0, busy=0; cycle after that, IDLE.
- Round-robin fairness: PRIORITY_MODE=0, m_request=4'b1111 held, each owner pulses m_done after 2 cycles -> grant order 0,1,2,3,0. Same stimulus with PRIORITY_MODE=1 -> master 0 granted every time.
- Watchdog: TIMEOUT_CYCLES=8, master 1 holds its request, never sends m_done -> grant lasts exactly 8 cycles, then timeout=1 for one cycle, timeout_id=1, m_grant=0. With TIMEOUT_CYCLES=0, the grant persists 100+ cycles.
- Non-owner done / no preemption: master 0 owns; m_done[3]=1 and m_request[3]=1 -> master 0 keeps the grant. Master 0 drops its request -> RELEASE, then master 3 is granted 2 cycles later.
- Reset mid-operation: assert reset (low) asynchronously between edges while master 2 is granted -> m_grant=0 and busy=0 immediately. After deassert with m_request=4'b1111 in round-robin mode -> master 0 is granted first.
